// File: rtl/uart_rx_counter.sv
// UART receiver: 2-flop input synchroniser, mid-bit sampling FSM with optional
// parity, registered result strobes, and a saturating good-frame counter.
module uart_rx_counter #(
  parameter int CLKS_PER_BIT = 1302,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int CNT_W        = 4,
  parameter int COUNT_MAX    = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_data,
  input  logic                 clear,
  output logic [DATA_BITS-1:0] rx_byte,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic [CNT_W-1:0]     receive_counter,
  output logic                 count_done
);

  localparam int TIMER_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W   = $clog2(DATA_BITS + 1);

  localparam logic [TIMER_W-1:0] T_HALF   = TIMER_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [TIMER_W-1:0] T_LAST   = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(COUNT_MAX);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_PARITY    = 3'd3;
  localparam logic [2:0] S_STOP      = 3'd4;
  localparam logic [2:0] S_WAIT_HIGH = 3'd5;

  logic                 rx_meta;
  logic                 rx_sync;
  logic [1:0]           sync_fill;
  logic [2:0]           state;
  logic [2:0]           state_next;
  logic [TIMER_W-1:0]   timer;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 parity_bit;
  logic                 bit_end;
  logic                 stop_tick;
  logic                 parity_ok;
  logic                 good_frame;

  assign bit_end    = (timer == T_LAST);
  assign stop_tick  = (state == S_STOP) && bit_end;
  assign parity_ok  = (PARITY == 0) || (((^shift_reg) ^ parity_bit) == (PARITY == 1));
  assign good_frame = stop_tick && rx_sync && parity_ok;
  assign count_done = (receive_counter == CNT_MAX);

  // Synchronise the serial line; sync_fill marks when rx_sync reflects the real pin
  // rather than its reset value, so a reset while the line is low cannot
  // release WAIT_HIGH on stale data.
  // NOTE: non-blocking (<=) for every flop so all registers update from the
  // same pre-edge values; blocking here would collapse the two-flop chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      sync_fill <= 2'b00;
    end else begin
      rx_meta   <= rx_data;
      rx_sync   <= rx_meta;
      sync_fill <= {sync_fill[0], 1'b1};
    end
  end

  // Next-state decode for the frame FSM.
  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (!rx_sync) state_next = S_START;
      end
      S_START: begin
        if (timer == T_HALF) state_next = rx_sync ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (bit_end && (bit_idx == IDX_LAST)) state_next = (PARITY != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (bit_end) state_next = S_STOP;
      end
      S_STOP: begin
        if (bit_end) state_next = rx_sync ? S_IDLE : S_WAIT_HIGH;
      end
      S_WAIT_HIGH: begin
        if (rx_sync && sync_fill[1]) state_next = S_IDLE;
      end
      default: state_next = S_WAIT_HIGH;
    endcase
  end

  // State register and bit timer; the timer restarts on every state change
  // and wraps each bit period while the state holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_WAIT_HIGH;
      timer <= '0;
    end else begin
      state <= state_next;
      if ((state_next != state) || bit_end) timer <= '0;
      else                                  timer <= timer + TIMER_W'(1);
    end
  end

  // Data path: shift data in LSB first, count data bits, capture parity bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg  <= '0;
      bit_idx    <= '0;
      parity_bit <= 1'b0;
    end else begin
      if (state == S_START) bit_idx <= '0;
      if ((state == S_DATA) && bit_end) begin
        shift_reg <= {rx_sync, shift_reg[DATA_BITS-1:1]};
        bit_idx   <= bit_idx + IDX_W'(1);
      end
      if ((state == S_PARITY) && bit_end) parity_bit <= rx_sync;
    end
  end

  // Result strobes, one cycle after the stop-bit sample; rx_byte moves only
  // on good frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_byte    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      rx_valid   <= good_frame;
      frame_err  <= stop_tick && !rx_sync;
      parity_err <= stop_tick && !parity_ok;
      if (good_frame) rx_byte <= shift_reg;
    end
  end

  // Good-frame counter: clear wins over an increment, saturates at COUNT_MAX.
  always_ff @(posedge clk) begin
    if (rst)                                       receive_counter <= '0;
    else if (clear)                                receive_counter <= '0;
    else if (rx_valid && (receive_counter < CNT_MAX)) receive_counter <= receive_counter + CNT_W'(1);
  end

endmodule

// File: tb/tb_uart_rx_counter.sv
// Self-checking bench for uart_rx_counter: an 8N1 instance and an 8E1 instance
// at 16 clocks per bit, directed scenarios plus randomized frames, checked
// every cycle against an event-queue model derived from the frame timing.
module tb_uart_rx_counter;

  localparam int CPB  = 16;
  localparam int H    = (CPB - 1) / 2;
  localparam int DB   = 8;
  localparam int CMAX = 9;

  typedef struct {
    int         cyc;
    bit         v;
    bit         fe;
    bit         pe;
    logic [7:0] d;
  } ev_t;

  logic       clk    = 1'b0;
  logic       rst    = 1'b1;
  logic       clear  = 1'b0;
  logic       line_a = 1'b1;
  logic       line_b = 1'b1;

  logic [7:0] a_byte, b_byte;
  logic       a_valid, b_valid, a_ferr, b_ferr, a_perr, b_perr, a_done, b_done;
  logic [3:0] a_cnt, b_cnt;

  int   cyc       = 0;
  int   clear_cyc = -1;
  bit   chk_en    = 1'b0;
  int   checks    = 0;
  int   errors    = 0;

  ev_t        q_a[$];
  ev_t        q_b[$];
  int         exp_cnt  [2];
  logic [7:0] exp_byte [2];

  int nv_a = 0, nv_b = 0, nfe_a = 0, nfe_b = 0, npe_a = 0, npe_b = 0;

  uart_rx_counter #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY(0), .CNT_W(4), .COUNT_MAX(CMAX)
  ) dut_a (
    .clk(clk), .rst(rst), .rx_data(line_a), .clear(clear),
    .rx_byte(a_byte), .rx_valid(a_valid), .frame_err(a_ferr), .parity_err(a_perr),
    .receive_counter(a_cnt), .count_done(a_done)
  );

  uart_rx_counter #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY(2), .CNT_W(4), .COUNT_MAX(CMAX)
  ) dut_b (
    .clk(clk), .rst(rst), .rx_data(line_b), .clear(clear),
    .rx_byte(b_byte), .rx_valid(b_valid), .frame_err(b_ferr), .parity_err(b_perr),
    .receive_counter(b_cnt), .count_done(b_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Clear is raised for exactly the cycle named by clear_cyc.
  always begin
    @(posedge clk);
    #1;
    clear = (cyc == clear_cyc);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare one DUT against the model for the current cycle, then advance the
  // model's counter and byte for the next cycle.
  task automatic model_step(input int d, input logic [15:0] act);
    ev_t         e;
    bit          hit;
    logic [15:0] exp;
    hit = 1'b0;
    e.cyc = -1; e.v = 1'b0; e.fe = 1'b0; e.pe = 1'b0; e.d = 8'h00;
    if (d == 0) begin
      if ((q_a.size() != 0) && (q_a[0].cyc == cyc)) begin e = q_a.pop_front(); hit = 1'b1; end
    end else begin
      if ((q_b.size() != 0) && (q_b[0].cyc == cyc)) begin e = q_b.pop_front(); hit = 1'b1; end
    end
    if (hit && e.v) exp_byte[d] = e.d;
    exp = {hit & e.v, hit & e.fe, hit & e.pe, exp_byte[d], 4'(exp_cnt[d]), exp_cnt[d] == CMAX};
    check((d == 0) ? "cycle_a" : "cycle_b", {16'h0, act}, {16'h0, exp});
    if (rst) begin
      exp_cnt[d]  = 0;
      exp_byte[d] = 8'h00;
      if (d == 0) q_a.delete(); else q_b.delete();
    end else if (clear) begin
      exp_cnt[d] = 0;
    end else if (hit && e.v && (exp_cnt[d] < CMAX)) begin
      exp_cnt[d] = exp_cnt[d] + 1;
    end
  endtask

  // Per-cycle comparison and pulse tally, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      model_step(0, {a_valid, a_ferr, a_perr, a_byte, a_cnt, a_done});
      model_step(1, {b_valid, b_ferr, b_perr, b_byte, b_cnt, b_done});
      nv_a  += int'(a_valid); nv_b  += int'(b_valid);
      nfe_a += int'(a_ferr);  nfe_b += int'(b_ferr);
      npe_a += int'(a_perr);  npe_b += int'(b_perr);
    end
  end

  task automatic hold(input int d, input logic v, input int n);
    if (d == 0) line_a = v; else line_b = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One frame on line d. The pin falls in the current cycle k; the stop bit is
  // sampled at k+2 (synchroniser) +1+H+(DB+P+1)*CPB and strobes appear one later.
  task automatic send_frame(input int d, input logic [7:0] data, input bit bad_par,
                            input bit stop, input int tail_low, input int gap);
    int   k;
    int   p;
    logic pbit;
    ev_t  e;
    k    = cyc;
    p    = (d == 1) ? 1 : 0;
    pbit = (^data) ^ bad_par;
    e.cyc = k + 3 + H + (DB + p + 1) * CPB + 1;
    e.v   = stop && !bad_par;
    e.fe  = !stop;
    e.pe  = bad_par;
    e.d   = data;
    if (d == 0) q_a.push_back(e); else q_b.push_back(e);
    hold(d, 1'b0, CPB);
    for (int i = 0; i < DB; i++) hold(d, data[i], CPB);
    if (p == 1) hold(d, pbit, CPB);
    hold(d, stop, CPB);
    if (!stop) hold(d, 1'b0, tail_low);
    hold(d, 1'b1, gap);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int         base;
    int         kind;
    int         k;
    logic [7:0] data;
    bit         bp;
    exp_cnt[0] = 0; exp_cnt[1] = 0;
    exp_byte[0] = 8'h00; exp_byte[1] = 8'h00;

    // Reset: three cycles high with the line idle.
    rst = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    check("reset_a_outputs", {16'h0, a_valid, a_ferr, a_perr, a_byte, a_cnt, a_done}, 32'h0);
    check("reset_b_outputs", {16'h0, b_valid, b_ferr, b_perr, b_byte, b_cnt, b_done}, 32'h0);
    hold(0, 1'b1, 50);
    check("idle_no_strobes", nv_a + nfe_a + npe_a + nv_b + nfe_b + npe_b, 0);

    // Single frame.
    send_frame(0, 8'hA5, 1'b0, 1'b1, 0, 20);
    check("single_byte", a_byte, 8'hA5);
    check("single_cnt", a_cnt, 1);
    check("single_valid_pulses", nv_a, 1);
    check("single_err_pulses", nfe_a + npe_a, 0);

    // Start glitch shorter than half a bit, then a real frame.
    hold(0, 1'b0, 4);
    hold(0, 1'b1, 20);
    check("glitch_no_strobe", nv_a + nfe_a + npe_a, 1);
    check("glitch_cnt", a_cnt, 1);
    send_frame(0, 8'h3C, 1'b0, 1'b1, 0, 20);
    check("after_glitch_byte", a_byte, 8'h3C);
    check("after_glitch_cnt", a_cnt, 2);

    // Framing error followed by a long break, then a good frame.
    send_frame(0, 8'hC3, 1'b0, 1'b0, 40, 10);
    check("frame_err_pulses", nfe_a, 1);
    check("frame_err_no_valid", nv_a, 2);
    check("frame_err_byte_kept", a_byte, 8'h3C);
    send_frame(0, 8'h5A, 1'b0, 1'b1, 0, 20);
    check("after_break_byte", a_byte, 8'h5A);
    check("after_break_cnt", a_cnt, 3);

    // Even parity: 0x07 with parity bit 0 is bad, with parity bit 1 is good.
    send_frame(1, 8'h07, 1'b1, 1'b1, 0, 20);
    check("parity_err_pulses", npe_b, 1);
    check("parity_err_cnt", b_cnt, 0);
    check("parity_err_no_valid", nv_b, 0);
    send_frame(1, 8'h07, 1'b0, 1'b1, 0, 20);
    check("parity_ok_byte", b_byte, 8'h07);
    check("parity_ok_cnt", b_cnt, 1);

    // Saturation: clear first, then ten back-to-back frames.
    clear_cyc = cyc + 1;
    hold(0, 1'b1, 4);
    check("clear_cnt", a_cnt, 0);
    check("clear_done", a_done, 0);
    base = nv_a;
    for (int i = 0; i < 10; i++) begin
      send_frame(0, 8'(i), 1'b0, 1'b1, 0, 0);
      if (i == 7) check("eighth_not_done", a_done, 0);
      if (i == 8) check("ninth_done", {a_done, a_cnt}, 5'h19);
    end
    hold(0, 1'b1, 10);
    check("saturated_cnt", a_cnt, 9);
    check("saturated_done", a_done, 1);
    check("saturated_pulses", nv_a - base, 10);
    check("saturated_byte", a_byte, 8'h09);

    // Clear in the same cycle as an rx_valid pulse: clear wins.
    k = cyc;
    clear_cyc = k + 3 + H + (DB + 1) * CPB + 1;
    send_frame(0, 8'h0A, 1'b0, 1'b1, 0, 10);
    check("clear_vs_valid_cnt", a_cnt, 0);
    check("clear_vs_valid_done", a_done, 0);
    check("clear_vs_valid_byte", a_byte, 8'h0A);
    check("clear_vs_valid_pulses", nv_a - base, 11);

    // Reset in the middle of a frame while the line is low.
    base = nv_a + nfe_a + npe_a;
    hold(0, 1'b0, CPB);
    hold(0, 1'b1, CPB);
    hold(0, 1'b0, 8);
    rst = 1'b1;
    hold(0, 1'b0, 3);
    rst = 1'b0;
    hold(0, 1'b0, 30);
    hold(0, 1'b1, 200);
    check("midreset_no_strobe", nv_a + nfe_a + npe_a - base, 0);
    check("midreset_a_state", {a_byte, a_cnt, a_done}, 0);
    check("midreset_b_cnt", b_cnt, 0);

    // Randomized traffic on both instances.
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 14; n++) begin
        kind = int'($urandom_range(0, 9));
        data = 8'($urandom);
        bp   = (d == 1) && ($urandom_range(0, 1) == 1);
        if (kind < 6) begin
          send_frame(d, data, 1'b0, 1'b1, 0, int'($urandom_range(0, 20)));
        end else if (kind == 6) begin
          hold(d, 1'b0, int'($urandom_range(1, 6)));
          hold(d, 1'b1, int'($urandom_range(10, 20)));
        end else if (kind == 7) begin
          send_frame(d, data, bp, 1'b0, int'($urandom_range(0, 40)), int'($urandom_range(4, 20)));
        end else begin
          send_frame(d, data, bp, 1'b1, 0, int'($urandom_range(0, 20)));
        end
      end
    end
    hold(0, 1'b1, 200);
    check("model_queue_drained", q_a.size() + q_b.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_counter.md
# uart_rx_counter

Parametrised UART receiver with an integrated valid-frame counter, used to load matrix operands from the host serial link. It oversamples `rx_data` on the system clock and decodes start, data, optional parity and stop bits. Each good frame is presented as a one-cycle strobe, and the frame counter raises `count_done` once a configured number of frames has arrived. It replaces the fixed 4-bit receive counter and adds parity, framing-error detection, saturation and software clear.

## Interface
- `CLKS_PER_BIT`, 1302: system clocks per bit, ≥ 4.
- `DATA_BITS`, 8: data bits per frame, 5–9, sent LSB first.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `CNT_W`, 4: width of `receive_counter`.
- `COUNT_MAX`, 9: count at which `count_done` asserts, ≤ 2^CNT_W − 1.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `rx_data`  in  1  asynchronous serial line, idle high.
- `clear`  in  1  synchronous clear of `receive_counter` and `count_done`.
- `rx_byte`  out  DATA_BITS  last good frame's data.
- `rx_valid`  out  1  one-cycle strobe: `rx_byte` holds new good frame.
- `frame_err`  out  1  one-cycle strobe: stop bit sampled low.
- `parity_err`  out  1  one-cycle strobe: parity mismatch.
- `receive_counter`  out  CNT_W  number of good frames, saturating.
- `count_done`  out  1  high while `receive_counter` == COUNT_MAX.

## Operation
- **Input synchroniser.** `rx_data` passes through a 2-flop synchroniser (`rx_sync`). Both flops reset to 1.
- **Bit timer.** The bit timer counts 0..CLKS_PER_BIT−1 and is zeroed on every state change. Define H = (CLKS_PER_BIT−1)/2, integer.
- **FSM states:** IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - **IDLE:** when `rx_sync` = 0, go to START.
  - **START:** at timer = H, sample `rx_sync`. If it is 1 (glitch), go to IDLE. Otherwise go to DATA with bit index 0.
  - **DATA:** at timer = CLKS_PER_BIT−1, shift the sample into the shift register, LSB first. After DATA_BITS samples, go to PARITY if PARITY ≠ 0, else to STOP.
  - **PARITY:** at timer = CLKS_PER_BIT−1, sample the parity bit, then go to STOP.
    - Odd parity: (data XOR parity bit) has an odd number of ones.
    - Even parity: the number of ones is even.
  - **STOP:** at timer = CLKS_PER_BIT−1, sample the stop bit and evaluate the frame.
    - Stop bit = 1 and parity OK: good frame. Go to IDLE immediately, so back-to-back frames are accepted.
    - Stop bit = 0: go to WAIT_HIGH.
    - Stop bit = 1 with a parity error: go to IDLE.
  - **WAIT_HIGH:** stay until `rx_sync` = 1, then go to IDLE. A break condition therefore never retriggers a frame.
- **Result strobes.** All strobes are registered one cycle after the stop sample.
  - Good frame: `rx_byte` ← shift register, `rx_valid` = 1.
  - Bad stop bit: `frame_err` = 1.
  - Bad parity: `parity_err` = 1.
  - `frame_err` and `parity_err` may assert together.
  - `rx_byte` changes only on good frames.
- **Counter.** It increments only on `rx_valid` and saturates at COUNT_MAX. `rx_valid` still pulses after saturation.
  - `count_done` is combinational from `receive_counter` == COUNT_MAX.
  - `clear` sets the counter to 0. When `clear` and an increment coincide, `clear` wins and the result is 0.
  - `clear` does not affect the FSM.
- **Reset.** All outputs go to 0, the shift register and timer go to 0, and the state goes to WAIT_HIGH. A reset mid-frame discards the frame and does not decode the remaining low bits as a start.

## Timing
- Let T be the first cycle in IDLE with `rx_sync` = 0. T is 2–3 cycles after the pin falls.
- START is entered at T+1. The start bit is sampled at T+1+H.
- Data bit k is sampled at T+1+H+(k+1)·CLKS_PER_BIT.
- The stop bit is sampled at S = T+1+H+(DATA_BITS+P+1)·CLKS_PER_BIT, where P = 1 if PARITY ≠ 0, else 0.
- `rx_valid`, `frame_err` and `parity_err` are high at cycle S+1 only.
- `receive_counter` shows the new value at S+2. `count_done` is high from the same cycle.
- Minimum spacing between `rx_valid` pulses equals the frame length. The next start edge is accepted from S+1.
- Tolerated baud mismatch is about ±(H/CLKS_PER_BIT)/(frame bits), roughly ±4 % at 8N1.

## Test plan
Unless stated otherwise, CLKS_PER_BIT = 16, 8N1, COUNT_MAX = 9.
1. **Reset.** Hold `rst` = 1 for 3 cycles with `rx_data` = 1, then release. Required: all outputs 0, and no strobe for 50 idle cycles.
2. **Single frame.** Send 0xA5. Required: `rx_byte` = 0xA5, `rx_valid` high for exactly 1 cycle at S+1, `receive_counter` = 1, no error strobes.
3. **Start glitch.** Drive `rx_data` low for 4 cycles (less than H = 7), then high. Required: no strobes, counter unchanged. A following frame 0x3C is received correctly.
4. **Framing error.** Send a frame with the stop bit low, then hold the line low for 40 cycles. Required: one `frame_err` pulse, no `rx_valid`, no retrigger. After the line returns high, 0x5A is received correctly.
5. **Even parity (PARITY = 2).** Send 0x07 with parity bit 0. Required: `parity_err` pulse, counter unchanged. Send 0x07 with parity bit 1. Required: `rx_valid`, `rx_byte` = 0x07.
6. **Saturation and clear.** Send 10 back-to-back frames 0x00..0x09. Required: `count_done` rises after the 9th, the counter holds at 9 after the 10th, and 10 `rx_valid` pulses occur. Then assert `clear` in the cycle of an `rx_valid`. Required: counter = 0 and `count_done` = 0 on the next cycle.
